uart_pkt_dispatch: RTL and testbench

Byte-stream packet dispatcher between the UART receiver and the DC channel / launch register banks inside `uart_api_dc`. It assembles received bytes into big-endian 32-bit words and decodes packet headers. It routes payload words as single-cycle register writes to one DC channel bank or to the launch bank, then pulses a launch start. Malformed headers and stalled packets cause an abort and resynchronization on the next header.

---
 rtl/uart_pkt_dispatch_if.sv | 39 +++
 rtl/uart_pkt_dispatch.sv | 148 ++++++++++++++
 tb/tb_uart_pkt_dispatch.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkt_dispatch_if.sv
// uart_pkt_dispatch_if: byte stream into the packet dispatcher and register-bank write port out of it
// Signals:
//   i_rx_valid, i_rx_data        one-cycle byte strobe and received byte (UART receiver side)
//   o_reg_wr_en/addr/data        one-hot channel bank write strobe, word index, shared write data
//   o_launch_wr_en/addr          launch bank write strobe and word index
//   o_launch_start               pulse after the last launch word
//   o_busy, o_err                packet in progress, header error / timeout abort pulse
// Modports: master drives the byte stream, slave is the dispatcher.
interface uart_pkt_dispatch_if #(
    parameter int NUM_CHANNEL = 4,
    parameter int TOTAL_REGS  = 8,
    parameter int LAUNCH_REGS = 4
);
    localparam int AW = $clog2(TOTAL_REGS);
    localparam int LW = $clog2(LAUNCH_REGS);

    logic                   i_rx_valid;
    logic [7:0]             i_rx_data;
    logic [NUM_CHANNEL-1:0] o_reg_wr_en;
    logic [AW-1:0]          o_reg_addr;
    logic [31:0]            o_reg_data;
    logic                   o_launch_wr_en;
    logic [LW-1:0]          o_launch_addr;
    logic                   o_launch_start;
    logic                   o_busy;
    logic                   o_err;

    modport master (
        output i_rx_valid, i_rx_data,
        input  o_reg_wr_en, o_reg_addr, o_reg_data, o_launch_wr_en, o_launch_addr,
               o_launch_start, o_busy, o_err
    );

    modport slave (
        input  i_rx_valid, i_rx_data,
        output o_reg_wr_en, o_reg_addr, o_reg_data, o_launch_wr_en, o_launch_addr,
               o_launch_start, o_busy, o_err
    );
endinterface

// File: rtl/uart_pkt_dispatch.sv
// uart_pkt_dispatch: assembles UART bytes into big-endian words, decodes packet headers and routes payload to DC channel / launch banks
// Ports:
//   i_clk       system clock
//   i_rst       synchronous active-high reset
//   bus (slave) byte stream in; registered channel/launch write strobes, address, data,
//               launch start pulse, busy level and error pulse out
module uart_pkt_dispatch #(
    parameter int NUM_CHANNEL    = 4,
    parameter int TOTAL_REGS     = 8,
    parameter int LAUNCH_REGS    = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    uart_pkt_dispatch_if.slave bus
);
    localparam int AW = $clog2(TOTAL_REGS);
    localparam int LW = $clog2(LAUNCH_REGS);
    localparam int WW = AW > LW ? AW : LW;
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {HDR, CH_DATA, LN_DATA, START} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [23:0]            sh_q, sh_d;
    logic [WW-1:0]          wcnt_q, wcnt_d;
    logic [NUM_CHANNEL-1:0] ch_q, ch_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [NUM_CHANNEL-1:0] reg_wr_en_q, reg_wr_en_d;
    logic [AW-1:0]          reg_addr_q, reg_addr_d;
    logic [31:0]            reg_data_q, reg_data_d;
    logic                   launch_wr_en_q, launch_wr_en_d;
    logic [LW-1:0]          launch_addr_q, launch_addr_d;
    logic                   launch_start_q, launch_start_d;
    logic                   err_q, err_d;
    logic [31:0]            word;
    logic                   word_done, busy, timeout;
    logic [NUM_CHANNEL-1:0] hdr_hit;

    // the fourth byte completes the word combinationally with the three buffered ones
    assign word      = {sh_q, bus.i_rx_data};
    assign word_done = bus.i_rx_valid && byte_cnt_q == 2'd3;
    assign busy      = state_q != HDR || byte_cnt_q != 2'd0;
    // a byte arriving in the cycle the limit is reached keeps the packet alive
    assign timeout   = busy && !bus.i_rx_valid && gap_q == GW'(TIMEOUT_CYCLES);

    // channel k header is all ones with bit k+8 cleared; hits are mutually exclusive
    for (genvar k = 0; k < NUM_CHANNEL; k++) begin : g_hdr
        assign hdr_hit[k] = word == ~(32'd1 << (k + 8));
    end

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = bus.i_rx_valid ? byte_cnt_q + 2'd1 : byte_cnt_q;
        sh_d           = bus.i_rx_valid ? {sh_q[15:0], bus.i_rx_data} : sh_q;
        wcnt_d         = wcnt_q;
        ch_d           = ch_q;
        gap_d          = bus.i_rx_valid || !busy ? '0 : gap_q + GW'(1);
        reg_wr_en_d    = '0;
        reg_addr_d     = reg_addr_q;
        reg_data_d     = reg_data_q;
        launch_wr_en_d = 1'b0;
        launch_addr_d  = launch_addr_q;
        launch_start_d = 1'b0;
        err_d          = 1'b0;
        unique case (state_q)
            HDR: if (word_done) begin
                wcnt_d = '0;
                if (word == 32'hFFFF_FFFF) begin
                    state_d = LN_DATA;
                end else if (|hdr_hit) begin
                    state_d = CH_DATA;
                    ch_d    = hdr_hit;
                end else begin
                    err_d = 1'b1;
                end
            end
            CH_DATA: if (word_done) begin
                reg_wr_en_d = ch_q;
                reg_addr_d  = AW'(wcnt_q);
                reg_data_d  = word;
                wcnt_d      = wcnt_q == WW'(TOTAL_REGS - 1) ? '0 : wcnt_q + WW'(1);
                state_d     = wcnt_q == WW'(TOTAL_REGS - 1) ? HDR : CH_DATA;
            end
            LN_DATA: if (word_done) begin
                launch_wr_en_d = 1'b1;
                launch_addr_d  = LW'(wcnt_q);
                reg_data_d     = word;
                wcnt_d         = wcnt_q == WW'(LAUNCH_REGS - 1) ? '0 : wcnt_q + WW'(1);
                state_d        = wcnt_q == WW'(LAUNCH_REGS - 1) ? START : LN_DATA;
            end
            START: begin
                launch_start_d = 1'b1;
                state_d        = HDR;
            end
        endcase
        // abort drops the partial packet; already written words are left in place
        if (timeout) begin
            state_d    = HDR;
            byte_cnt_d = '0;
            wcnt_d     = '0;
            gap_d      = '0;
            err_d      = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= HDR;
            byte_cnt_q     <= '0;
            sh_q           <= '0;
            wcnt_q         <= '0;
            ch_q           <= '0;
            gap_q          <= '0;
            reg_wr_en_q    <= '0;
            reg_addr_q     <= '0;
            reg_data_q     <= '0;
            launch_wr_en_q <= 1'b0;
            launch_addr_q  <= '0;
            launch_start_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            sh_q           <= sh_d;
            wcnt_q         <= wcnt_d;
            ch_q           <= ch_d;
            gap_q          <= gap_d;
            reg_wr_en_q    <= reg_wr_en_d;
            reg_addr_q     <= reg_addr_d;
            reg_data_q     <= reg_data_d;
            launch_wr_en_q <= launch_wr_en_d;
            launch_addr_q  <= launch_addr_d;
            launch_start_q <= launch_start_d;
            err_q          <= err_d;
        end
    end

    assign bus.o_reg_wr_en    = reg_wr_en_q;
    assign bus.o_reg_addr     = reg_addr_q;
    assign bus.o_reg_data     = reg_data_q;
    assign bus.o_launch_wr_en = launch_wr_en_q;
    assign bus.o_launch_addr  = launch_addr_q;
    assign bus.o_launch_start = launch_start_q;
    assign bus.o_busy         = busy;
    assign bus.o_err          = err_q;
endmodule

// File: tb/tb_uart_pkt_dispatch.sv
// tb_uart_pkt_dispatch: directed checks of word assembly, channel/launch routing, header errors, timeout and reset abort
module tb_uart_pkt_dispatch;
    localparam int NCH = 4;
    localparam int TR  = 8;
    localparam int LR  = 4;
    localparam int TO  = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_pkt_dispatch_if #(.NUM_CHANNEL(NCH), .TOTAL_REGS(TR), .LAUNCH_REGS(LR)) bus ();

    uart_pkt_dispatch #(
        .NUM_CHANNEL(NCH), .TOTAL_REGS(TR), .LAUNCH_REGS(LR), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    // kind: one-hot channel strobe, 'h10 launch write, 'h20 launch start
    typedef struct {
        logic [31:0] kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t got_q[$];
    ev_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    logic [31:0] hdr [NCH] = '{32'hFFFF_FEFF, 32'hFFFF_FDFF, 32'hFFFF_FBFF, 32'hFFFF_F7FF};
    logic [31:0] lw  [LR]  = '{32'h0000_000F, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_reg_wr_en != '0)
                got_q.push_back('{32'(bus.o_reg_wr_en), 32'(bus.o_reg_addr), bus.o_reg_data});
            if (bus.o_launch_wr_en)
                got_q.push_back('{32'h10, 32'(bus.o_launch_addr), bus.o_reg_data});
            if (bus.o_launch_start)
                got_q.push_back('{32'h20, 32'd0, 32'd0});
            if (bus.o_err)
                err_pulses++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_ev(input logic [31:0] kind, input logic [31:0] addr, input logic [31:0] data);
        exp_q.push_back('{kind, addr, data});
    endtask

    task automatic send_ch(input int k, input logic [31:0] base);
        send_word(hdr[k]);
        for (int i = 0; i < TR; i++) begin
            send_word(base + 32'(i));
            exp_ev(32'd1 << k, 32'(i), base + 32'(i));
        end
    endtask

    task automatic send_ln(input logic [31:0] base);
        send_word(32'hFFFF_FFFF);
        for (int i = 0; i < LR; i++) begin
            send_word(base + 32'(i));
            exp_ev(32'h10, 32'(i), base + 32'(i));
        end
        exp_ev(32'h20, 32'd0, 32'd0);
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_kind"}, got_q[i].kind, exp_q[i].kind);
            check({tag, "_addr"}, got_q[i].addr, exp_q[i].addr);
            check({tag, "_data"}, got_q[i].data, exp_q[i].data);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        idle(3);
        check("rst_wr_en", 32'(bus.o_reg_wr_en), 32'h0);
        check("rst_addr", 32'(bus.o_reg_addr), 32'h0);
        check("rst_data", bus.o_reg_data, 32'h0);
        check("rst_ln_wr", 32'(bus.o_launch_wr_en), 32'h0);
        check("rst_ln_addr", 32'(bus.o_launch_addr), 32'h0);
        check("rst_start", 32'(bus.o_launch_start), 32'h0);
        check("rst_busy", 32'(bus.o_busy), 32'h0);
        check("rst_err", 32'(bus.o_err), 32'h0);
        rst = 1'b0;
        idle(2);

        // channel 2 packet with per-word latency checks
        send_word(32'hFFFF_FBFF);
        check("c2_hdr_nowr", 32'(bus.o_reg_wr_en), 32'h0);
        check("c2_hdr_busy", 32'(bus.o_busy), 32'h1);
        for (int i = 0; i < TR; i++) begin
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(8'h00);
            check("c2_pre_wr", 32'(bus.o_reg_wr_en), 32'h0);
            send_byte(8'(i));
            check("c2_wr_lat", 32'(bus.o_reg_wr_en), 32'h4);
            exp_ev(32'h4, 32'(i), 32'(i));
        end
        idle(2);
        check("c2_busy_end", 32'(bus.o_busy), 32'h0);
        compare("c2");
        check("c2_err", 32'(err_pulses), 32'd0);

        // launch packet, start pulse exactly one cycle after the last write
        send_word(32'hFFFF_FFFF);
        for (int i = 0; i < LR; i++) begin
            send_word(lw[i]);
            exp_ev(32'h10, 32'(i), lw[i]);
        end
        check("ln_last_wr", 32'(bus.o_launch_wr_en), 32'h1);
        check("ln_start_early", 32'(bus.o_launch_start), 32'h0);
        idle(1);
        check("ln_start", 32'(bus.o_launch_start), 32'h1);
        idle(1);
        check("ln_start_once", 32'(bus.o_launch_start), 32'h0);
        exp_ev(32'h20, 32'd0, 32'd0);
        idle(2);
        compare("ln");
        check("ln_busy", 32'(bus.o_busy), 32'h0);
        check("ln_err", 32'(err_pulses), 32'd0);

        // invalid header then a good channel 0 packet
        send_word(32'h1234_5678);
        check("bad_err", 32'(bus.o_err), 32'h1);
        check("bad_busy", 32'(bus.o_busy), 32'h0);
        idle(1);
        check("bad_err_pulse", 32'(bus.o_err), 32'h0);
        send_ch(0, 32'h1000_0000);
        idle(2);
        compare("bad");
        check("bad_err_cnt", 32'(err_pulses), 32'd1);

        // timeout after channel 1 header plus two bytes
        send_word(hdr[1]);
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle(TO);
        check("to_early", 32'(bus.o_err), 32'h0);
        check("to_busy_pre", 32'(bus.o_busy), 32'h1);
        idle(1);
        check("to_err", 32'(bus.o_err), 32'h1);
        check("to_busy", 32'(bus.o_busy), 32'h0);
        idle(1);
        check("to_err_pulse", 32'(bus.o_err), 32'h0);
        idle(10);
        send_ln(32'h5000_0000);
        idle(3);
        compare("to");
        check("to_err_cnt", 32'(err_pulses), 32'd2);

        // byte landing exactly on the timeout cycle is consumed
        send_word(hdr[3]);
        send_byte(8'h12);
        idle(TO);
        send_byte(8'h34);
        check("bnd_no_err", 32'(bus.o_err), 32'h0);
        send_byte(8'h56);
        send_byte(8'h78);
        check("bnd_wr", 32'(bus.o_reg_wr_en), 32'h8);
        exp_ev(32'h8, 32'd0, 32'h1234_5678);
        idle(TO + 10);
        compare("bnd");
        check("bnd_err_cnt", 32'(err_pulses), 32'd3);

        // reset after byte 5 aborts silently
        send_word(hdr[0]);
        send_byte(8'h55);
        rst = 1'b1;
        idle(1);
        check("mrst_busy", 32'(bus.o_busy), 32'h0);
        check("mrst_wr", 32'(bus.o_reg_wr_en), 32'h0);
        check("mrst_err", 32'(bus.o_err), 32'h0);
        rst = 1'b0;
        idle(1);
        send_ch(2, 32'h2000_0000);
        idle(2);
        compare("mrst");
        check("mrst_err_cnt", 32'(err_pulses), 32'd3);

        // back-to-back channel 0..3 then launch, no idle between packets
        for (int k = 0; k < NCH; k++) send_ch(k, 32'hC000_0000 | (32'(k) << 16));
        send_ln(32'hD000_0000);
        idle(3);
        compare("b2b");
        check("b2b_err_cnt", 32'(err_pulses), 32'd3);
        check("b2b_busy", 32'(bus.o_busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
